id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//  RV32I decode stage; sits between the fetch stage and EXE. Registers the
//  {inst,pc} bus from fetch, reads the 32x32 register file (forwarding from
//  EXE/MEM/WB) and extracts the immediate. Resolves conditional branches and JAL,
//  redirecting fetch via id_if_br_bus. Replays on load-use; squashes wrong-path fetches.
// PARAMETERS
//  RESET_PC   32'h0  pc held in ds_pc while reset is asserted
// PORTS
//  clk             in   1    clock, rising edge
//  rst_n           in   1    reset, asynchronous, active-low
//  if_id_bus_in    in   64   {inst[63:32], pc[31:0]} from fetch, valid every cycle
//  exe_jmp_flag    in   1    EXE redirect (JALR) taken this cycle
//  exe_fwd_bus     in   39   {we, is_load, rd[4:0], data[31:0]} result in EXE
//  mem_fwd_bus     in   38   {we, rd[4:0], data[31:0]} result in MEM
//  wb_we           in   1    regfile write enable
//  wb_rd           in   5    regfile write address
//  wb_wdata        in   32   regfile write data
//  id_if_br_bus    out  33   {br_flag, br_target[31:0]} to fetch, combinational
//  id_exe_bus_out  out  166  {valid, pc, inst, rs1_val, rs2_val, imm, rd[4:0]}
// BEHAVIOUR
//  - Reset: ds_valid=0, ds_inst=0, ds_pc=RESET_PC, squash_q=0, all regfile entries 0.
//    While reset is asserted: id_if_br_bus=0; id_exe_bus_out valid bit 0.
//  - Every rising edge: ds_inst/ds_pc <= if_id_bus_in. ds_valid <= !squash_now.
//    squash_q <= squash_now. No stall; latency fetch->EXE bus = 1 cycle.
//  - squash_now = br_flag | exe_jmp_flag. A set squash_q forces no extra action;
//    the flop is only observable for debug.
//  - Live: live = ds_valid & !exe_jmp_flag. Wrong-path instr dies at EXE redirect.
//  - rs1 is used by all opcodes except LUI(0110111), AUIPC(0010111), JAL(1101111).
//    rs2 is used only by R(0110011), S(0100011), B(1100011).
//  - Operand select per source: x0 -> 0. Otherwise the first match wins:
//    EXE(we & rd match), then MEM, then WB, then RF. WB match is same-cycle write-through.
//  - Load-use: live & exe.we & exe.is_load & exe.rd!=0 & exe.rd==used rs.
//    -> br_flag=1, br_target=ds_pc (replay). Output valid=0.
//  - Branch, B-type, live, no load-use: compare funct3 000/001/100/101/110/111.
//    The compares are EQ/NE/LT/GE (signed) and LTU/GEU (unsigned).
//    If taken: br_flag=1, br_target=ds_pc+immB. Not taken: br_flag=0.
//    Illegal funct3 is treated as not taken.
//  - JAL, live: br_flag=1, br_target=ds_pc+immJ. Output valid=1, rd passed for link.
//  - br_flag is never asserted when !live. Fetch gives br priority over jmp, so
//    simultaneous EXE jump and ID branch must yield br_flag=0.
//  - Immediates, sign-extended:
//    I: 0010011, 0000011, 1100111. S: 0100011. B: 1100011 (bit0=0).
//    U: 0110111, 0010111 (low 12 zero). J: 1101111 (bit0=0). Other opcodes: imm=0.
//  - rd field: inst[11:7] for writers. Forced 0 for B, S, and invalid slots.
//  - Output bus valid = live & !load_use. Other fields are driven even when invalid.
//  - Target addition wraps modulo 2^32.
//  - Regfile writes to x0 are ignored. A write and a read at the same address return the new data.
//  - Reset mid-operation: all state is cleared asynchronously. Pipeline resumes from RESET_PC fetch.
// TESTING
//  - Reset release, fetch pc 0,4,8 with ADDI x1,x0,5:
//    -> valid=1 one cycle later, imm=5, rd=1, rs1_val=0.
//  - BEQ x0,x0,+16 at pc 0x20 -> br_bus={1,0x30} the same cycle.
//    The next latched instr (pc 0x24) has valid=0. Fetch continues from 0x30.
//  - LW x5 in EXE (is_load=1, rd=5), ADD x6,x5,x5 in ID -> br_bus={1,ds_pc}, valid=0.
//    The replayed ADD then forwards from MEM with the load data.
//  - exe_jmp_flag=1 while ID holds taken BNE -> br_flag=0, valid=0.
//    The next latched slot is also invalid.
//  - wb write x7=0xDEADBEEF while ID reads x7 -> rs1_val=0xDEADBEEF.
//    EXE and MEM both writing x7 -> the EXE data is selected.
//  - JAL x1,-8 at pc 0x4 -> br_target=0xFFFFFFFC (wrap), valid=1, rd=1.
//    Write to x0 via WB, then read x0 -> 0.

Source files
------------

// File: rtl/id_stage_if.sv
// Fetch/forwarding/writeback bundle around the RV32I decode stage.
// master drives the stage inputs, slave is the decode stage itself.
interface id_stage_if;
  logic [63:0]  if_id_bus_in;
  logic         exe_jmp_flag;
  logic [38:0]  exe_fwd_bus;
  logic [37:0]  mem_fwd_bus;
  logic         wb_we;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_wdata;
  logic [32:0]  id_if_br_bus;
  logic [165:0] id_exe_bus_out;
  logic         dbg_squash;

  modport master (
    output if_id_bus_in, exe_jmp_flag,
    output exe_fwd_bus, mem_fwd_bus,
    output wb_we, wb_rd, wb_wdata,
    input  id_if_br_bus, id_exe_bus_out,
    input  dbg_squash
  );

  modport slave (
    input  if_id_bus_in, exe_jmp_flag,
    input  exe_fwd_bus, mem_fwd_bus,
    input  wb_we, wb_rd, wb_wdata,
    output id_if_br_bus, id_exe_bus_out,
    output dbg_squash
  );
endinterface

// File: rtl/id_stage.sv
// RV32I decode: regfile read with forwarding, immediates,
// branch/JAL resolution, load-use replay and wrong-path squash.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic      clk,
  input logic      rst_n,
  id_stage_if.slave bus
);

  logic        ds_valid;
  logic        squash_q;
  logic [31:0] ds_inst;
  logic [31:0] ds_pc;
  logic [31:0] rf [32];

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [4:0]  rs  [2];
  logic [31:0] val [2];

  assign op    = ds_inst[6:0];
  assign f3    = ds_inst[14:12];
  assign rd    = ds_inst[11:7];
  assign rs[0] = ds_inst[19:15];
  assign rs[1] = ds_inst[24:20];

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_br, is_ld, is_st, is_alui, is_alu;

  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_alui  = op == 7'b0010011;
  assign is_alu   = op == 7'b0110011;

  logic use_rs [2];
  assign use_rs[0] = ~(is_lui | is_auipc | is_jal);
  assign use_rs[1] = is_alu | is_st | is_br;

  logic        ex_we, ex_ld, mm_we;
  logic [4:0]  ex_rd, mm_rd;
  logic [31:0] ex_data, mm_data;

  assign {ex_we, ex_ld, ex_rd, ex_data} = bus.exe_fwd_bus;
  assign {mm_we, mm_rd, mm_data} = bus.mem_fwd_bus;

  // Youngest producer wins; WB match is the same-cycle write-through.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      if (rs[k] == 5'd0)
        val[k] = '0;
      else if (ex_we && ex_rd == rs[k])
        val[k] = ex_data;
      else if (mm_we && mm_rd == rs[k])
        val[k] = mm_data;
      else if (bus.wb_we && bus.wb_rd == rs[k])
        val[k] = bus.wb_wdata;
      else
        val[k] = rf[rs[k]];
    end
  end

  logic [31:0] imm;

  always_comb begin
    imm = '0;
    unique case (1'b1)
      is_alui | is_ld | is_jalr:
        imm = {{20{ds_inst[31]}}, ds_inst[31:20]};
      is_st:
        imm = {{20{ds_inst[31]}}, ds_inst[31:25],
               ds_inst[11:7]};
      is_br:
        imm = {{19{ds_inst[31]}}, ds_inst[31],
               ds_inst[7], ds_inst[30:25],
               ds_inst[11:8], 1'b0};
      is_lui | is_auipc:
        imm = {ds_inst[31:12], 12'h0};
      is_jal:
        imm = {{11{ds_inst[31]}}, ds_inst[31],
               ds_inst[19:12], ds_inst[20],
               ds_inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  logic taken;

  always_comb begin
    taken = 1'b0;
    unique case (f3)
      3'b000:  taken = val[0] == val[1];
      3'b001:  taken = val[0] != val[1];
      3'b100:  taken = $signed(val[0]) < $signed(val[1]);
      3'b101:  taken = $signed(val[0]) >= $signed(val[1]);
      3'b110:  taken = val[0] < val[1];
      3'b111:  taken = val[0] >= val[1];
      default: taken = 1'b0;
    endcase
  end

  logic live, load_use, br_flag, squash_now;
  logic out_valid;
  logic [31:0] br_target;
  logic [4:0]  out_rd;

  assign live = ds_valid & ~bus.exe_jmp_flag;

  assign load_use = live & ex_we & ex_ld
                  & (ex_rd != 5'd0)
                  & ((use_rs[0] & (ex_rd == rs[0]))
                   | (use_rs[1] & (ex_rd == rs[1])));

  always_comb begin
    br_flag   = 1'b0;
    br_target = ds_pc;
    if (load_use) begin
      br_flag = 1'b1;
    end else if (live & is_jal) begin
      br_flag   = 1'b1;
      br_target = ds_pc + imm;
    end else if (live & is_br & taken) begin
      br_flag   = 1'b1;
      br_target = ds_pc + imm;
    end
  end

  assign squash_now = br_flag | bus.exe_jmp_flag;
  assign out_valid  = live & ~load_use;
  assign out_rd     = (out_valid & ~(is_br | is_st)) ? rd : '0;

  assign bus.id_if_br_bus =
    br_flag ? {1'b1, br_target} : '0;
  assign bus.id_exe_bus_out =
    {out_valid, ds_pc, ds_inst, val[0], val[1], imm, out_rd};
  assign bus.dbg_squash = squash_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_valid <= 1'b0;
      squash_q <= 1'b0;
      ds_inst  <= '0;
      ds_pc    <= RESET_PC;
    end else begin
      ds_valid <= ~squash_now;
      squash_q <= squash_now;
      ds_inst  <= bus.if_id_bus_in[63:32];
      ds_pc    <= bus.if_id_bus_in[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (bus.wb_we && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_wdata;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Randomized bench for id_stage against a spec-level model
// of the decode slot, forwarding and register file.
module tb_id_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  id_stage_if bus ();

  id_stage #(.RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic        m_valid, m_sq;
  logic [31:0] m_inst, m_pc;
  logic [31:0] m_rf [32];
  logic [32:0] last_br;
  logic [31:0] fpc;

  task automatic check(string tag, logic [165:0] got,
                       logic [165:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] opnd(logic [4:0] r);
    if (r == 0) return 32'h0;
    if (bus.exe_fwd_bus[38] && bus.exe_fwd_bus[36:32] == r)
      return bus.exe_fwd_bus[31:0];
    if (bus.mem_fwd_bus[37] && bus.mem_fwd_bus[36:32] == r)
      return bus.mem_fwd_bus[31:0];
    if (bus.wb_we && bus.wb_rd == r) return bus.wb_wdata;
    return m_rf[r];
  endfunction

  function automatic logic [31:0] imm_of(logic [31:0] i);
    logic [31:0] ii, ss;
    ii = $signed(i) >>> 20;
    ss = (ii & 32'hFFFF_FFE0) | {27'h0, i[11:7]};
    case (i[6:0])
      7'h13, 7'h03, 7'h67: return ii;
      7'h23: return ss;
      7'h63: return (ss & 32'hFFFF_F7E0)
                  | ({31'h0, i[7]} << 11)
                  | ({28'h0, i[11:8]} << 1);
      7'h37, 7'h17: return i & 32'hFFFF_F000;
      7'h6F: begin
        logic signed [20:0] j;
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        return 32'($signed(j));
      end
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_eval(output logic [32:0] br,
                            output logic [165:0] out);
    logic [6:0]  op;
    logic [4:0]  e_rd;
    logic [31:0] a, b, im;
    logic        live, u1, u2, lu, tk, v;
    op   = m_inst[6:0];
    live = m_valid && !bus.exe_jmp_flag;
    u1   = !(op inside {7'h37, 7'h17, 7'h6F});
    u2   = op inside {7'h33, 7'h23, 7'h63};
    a    = opnd(m_inst[19:15]);
    b    = opnd(m_inst[24:20]);
    im   = imm_of(m_inst);
    e_rd = bus.exe_fwd_bus[36:32];
    lu = live && bus.exe_fwd_bus[38] && bus.exe_fwd_bus[37]
      && e_rd != 0
      && ((u1 && e_rd == m_inst[19:15])
       || (u2 && e_rd == m_inst[24:20]));
    case (m_inst[14:12])
      3'd0: tk = a == b;
      3'd1: tk = a != b;
      3'd4: tk = $signed(a) < $signed(b);
      3'd5: tk = $signed(a) >= $signed(b);
      3'd6: tk = a < b;
      3'd7: tk = a >= b;
      default: tk = 1'b0;
    endcase
    br = '0;
    if (lu) br = {1'b1, m_pc};
    else if (live && op == 7'h6F) br = {1'b1, m_pc + im};
    else if (live && op == 7'h63 && tk) br = {1'b1, m_pc + im};
    v = live && !lu;
    out = {v, m_pc, m_inst, a, b, im,
           (v && op != 7'h63 && op != 7'h23) ? m_inst[11:7] : 5'd0};
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_sq    = 0;
    m_inst  = '0;
    m_pc    = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
  endtask

  task automatic cyc();
    logic [32:0]  br;
    logic [165:0] out;
    #1;
    model_eval(br, out);
    check("br_bus", 166'(bus.id_if_br_bus), 166'(br));
    check("exe_bus", bus.id_exe_bus_out, out);
    check("squash_q", 166'(bus.dbg_squash), 166'(m_sq));
    last_br = br;
    if (bus.wb_we && bus.wb_rd != 0) m_rf[bus.wb_rd] = bus.wb_wdata;
    m_sq    = br[32] | bus.exe_jmp_flag;
    m_valid = !m_sq;
    m_inst  = bus.if_id_bus_in[63:32];
    m_pc    = bus.if_id_bus_in[31:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr();
    bus.exe_jmp_flag = 0;
    bus.exe_fwd_bus  = '0;
    bus.mem_fwd_bus  = '0;
    bus.wb_we        = 0;
    bus.wb_rd        = '0;
    bus.wb_wdata     = '0;
  endtask

  task automatic feed(logic [31:0] ins, logic [31:0] pc);
    bus.if_id_bus_in = {ins, pc};
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_br", 166'(bus.id_if_br_bus), 166'(0));
    check("rst_valid", 166'(bus.id_exe_bus_out[165]), 166'(0));
    check("rst_pc", 166'(bus.id_exe_bus_out[164:133]), 166'(0));
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom;
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    i[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0: i[6:0] = 7'h13;
      1: i[6:0] = 7'h03;
      2: i[6:0] = 7'h67;
      3: i[6:0] = 7'h23;
      4, 5: i[6:0] = 7'h63;
      6: i[6:0] = 7'h37;
      7: i[6:0] = 7'h17;
      8: i[6:0] = 7'h6F;
      9: i[6:0] = 7'h33;
      default: i[6:0] = 7'h0F;
    endcase
    return i;
  endfunction

  localparam logic [31:0] ADDI1 = 32'h0050_0093;
  localparam logic [31:0] BEQ16 = 32'h0000_0863;
  localparam logic [31:0] ADD6  = 32'h0052_8333;
  localparam logic [31:0] BNE8  = 32'h0000_9463;
  localparam logic [31:0] RD_X7 = 32'h0003_8113;
  localparam logic [31:0] RD_X0 = 32'h0000_0113;
  localparam logic [31:0] JALM8 = 32'hFF9F_F0EF;

  initial begin
    rst_n = 0;
    clr();
    feed(32'h0, 32'h0);
    @(negedge clk);
    do_reset();

    feed(ADDI1, 32'h0); cyc();
    feed(ADDI1, 32'h4); #1;
    check("addi_v", 166'(bus.id_exe_bus_out[165]), 166'(1));
    check("addi_imm", 166'(bus.id_exe_bus_out[36:5]), 166'(5));
    check("addi_rd", 166'(bus.id_exe_bus_out[4:0]), 166'(1));
    check("addi_rs1", 166'(bus.id_exe_bus_out[100:69]), 166'(0));
    cyc();
    feed(ADDI1, 32'h8); cyc();

    feed(BEQ16, 32'h20); cyc();
    feed(ADDI1, 32'h24); #1;
    check("beq_br", 166'(bus.id_if_br_bus), 166'({1'b1, 32'h30}));
    cyc();
    feed(ADDI1, 32'h30); #1;
    check("beq_shadow", 166'(bus.id_exe_bus_out[165]), 166'(0));
    cyc();

    feed(ADD6, 32'h40); cyc();
    bus.exe_fwd_bus = {1'b1, 1'b1, 5'd5, 32'hAAAA};
    feed(ADD6, 32'h44); #1;
    check("lu_br", 166'(bus.id_if_br_bus), 166'({1'b1, 32'h40}));
    check("lu_valid", 166'(bus.id_exe_bus_out[165]), 166'(0));
    cyc();
    clr(); feed(ADD6, 32'h40); cyc();
    bus.mem_fwd_bus = {1'b1, 5'd5, 32'h1234};
    feed(ADDI1, 32'h44); #1;
    check("replay_rs2", 166'(bus.id_exe_bus_out[68:37]), 166'(32'h1234));
    cyc();
    clr();

    feed(BNE8, 32'h50); cyc();
    bus.exe_fwd_bus  = {1'b1, 1'b0, 5'd1, 32'h7};
    bus.exe_jmp_flag = 1;
    feed(ADDI1, 32'h54); #1;
    check("jmp_br", 166'(bus.id_if_br_bus), 166'(0));
    cyc();
    clr(); feed(ADDI1, 32'h58); #1;
    check("jmp_shadow", 166'(bus.id_exe_bus_out[165]), 166'(0));
    cyc();

    feed(RD_X7, 32'h60); cyc();
    bus.wb_we = 1; bus.wb_rd = 5'd7; bus.wb_wdata = 32'hDEADBEEF;
    feed(RD_X7, 32'h64); #1;
    check("wb_thru", 166'(bus.id_exe_bus_out[100:69]), 166'(32'hDEADBEEF));
    cyc();
    clr();
    bus.exe_fwd_bus = {1'b1, 1'b0, 5'd7, 32'h1111};
    bus.mem_fwd_bus = {1'b1, 5'd7, 32'h2222};
    feed(JALM8, 32'h4); #1;
    check("exe_prio", 166'(bus.id_exe_bus_out[100:69]), 166'(32'h1111));
    cyc();
    clr();
    bus.wb_we = 1; bus.wb_rd = 5'd0; bus.wb_wdata = 32'hFF;
    feed(RD_X0, 32'h8); #1;
    check("jal_br", 166'(bus.id_if_br_bus), 166'({1'b1, 32'hFFFF_FFFC}));
    check("jal_rd", 166'(bus.id_exe_bus_out[4:0]), 166'(1));
    cyc();
    clr(); feed(RD_X0, 32'hC); #1;
    check("x0_read", 166'(bus.id_exe_bus_out[100:69]), 166'(0));
    cyc();

    fpc = 32'h100;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        do_reset();
        fpc = 32'h0;
      end
      bus.exe_jmp_flag = ($urandom_range(0, 7) == 0);
      bus.exe_fwd_bus = {1'($urandom), ($urandom_range(0, 3) == 0),
                         5'($urandom_range(0, 7)), 32'($urandom)};
      bus.mem_fwd_bus = {1'($urandom), 5'($urandom_range(0, 7)),
                         32'($urandom)};
      bus.wb_we    = 1'($urandom);
      bus.wb_rd    = 5'($urandom_range(0, 7));
      bus.wb_wdata = $urandom;
      feed(rand_inst(), fpc);
      cyc();
      fpc = last_br[32] ? last_br[31:0] : fpc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
